pc_lockstep_checker: RTL
========================

Name: pc_lockstep_checker

Overview:
- Parametrised in-order checker: compares PCs retired by the core (up to LANES per cycle) against expected PCs streamed from the instruction-set simulator side through an internal FIFO.
- Reports per-group miss with first offending try/factual pair, plus saturating match/miss counters and a sticky error.
- Sits between the core retire port and the simulator interface in the lockstep bench. Generalises the single-lane, unbuffered PC compare to multi-lane, buffered, two-mode operation.

Parameters:
XLEN, 64, PC width in bits
LANES, 2, retire lanes per cycle (1..4)
DEPTH, 8, expected-PC FIFO depth, power of two, >= LANES
CNT_W, 16, width of match/miss counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = ADVANCE (every compare consumes an expected PC), 1 = RETRY (only a match consumes)
clear  in  1  synchronous clear of counters, sticky_err, proto_err
ref_valid  in  1  expected PC offered
ref_pc  in  XLEN  expected (factual) PC
ref_ready  out  1  FIFO accepts ref_pc
ret_valid  in  LANES  per-lane retire valid, lane 0 oldest
ret_pc  in  LANES*XLEN  lane i PC at bits [i*XLEN +: XLEN]
ret_ready  out  1  retire group accepted
miss  out  1  one-cycle pulse: previous accepted group had >= 1 miss
miss_pc_try  out  XLEN  retired PC of first missing lane of that group
miss_pc_factual  out  XLEN  expected PC it was compared with
match_cnt  out  CNT_W  saturating count of matching lanes
miss_cnt  out  CNT_W  saturating count of missing lanes
sticky_err  out  1  set on any miss, held until clear
proto_err  out  1  sticky: non-contiguous ret_valid seen
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FIFO empty, all outputs 0 (ref_ready and ret_ready then follow from occupancy once rst_n is high). Reset mid-stream discards FIFO contents and pending miss.
- ref_ready = (fifo_level < DEPTH); push on ref_valid && ref_ready.
- ret_ready = (fifo_level >= LANES), computed from registered level only, not from same-cycle push.
- Group accepted when ret_ready && |ret_valid. Active lanes = contiguous valid prefix from lane 0. Any valid bit above the first 0 sets proto_err; those lanes are ignored.
- Compare in lane order. Lane i uses FIFO entry head+k, where k = entries consumed by lanes 0..i-1 this group.
- ADVANCE: each active lane consumes 1 entry, match or miss.
- RETRY: a matching lane consumes 1 entry; a missing lane consumes 0, so the next lane compares against the same entry.
- Same-cycle push and pop: level_next = level + push - pops; head and tail wrap modulo DEPTH.
- Latency: miss, miss_pc_try, miss_pc_factual and counter updates are registered and appear the cycle after acceptance.
- miss is low when no group is accepted. miss_pc_* hold their last captured values until the next miss.
- Counters add per-group matches/misses (0..LANES) and saturate at all-ones, with no wrap.
- sticky_err sets on the miss cycle.
- clear zeroes counters, sticky_err and proto_err. If clear and a counted event coincide, clear wins for that cycle. clear does not touch the FIFO or miss_pc_*.
- mode is sampled per accepted group; changing it between groups is legal.

Test Plan:
- LANES=1, RETRY: push 0x0,0x1000,0x1004,0x1008,0x100C,0x1010; retire 0x0,0x1000,0x1004,0xAAAA1008,0xBBBB1008,0x1008,0x100C,0xCCCC1010,0xDDDD1010,0x1010 -> miss pulses on 0xAAAA1008/0xBBBB1008/0xCCCC1010/0xDDDD1010 with factual 0x1008,0x1008,0x1010,0x1010; match_cnt=6, miss_cnt=4, fifo_level=0, sticky_err=1.
- Same stimulus, ADVANCE, 10 expected PCs pushed (0x0..0x1010 padded with 0x1014,0x1018,0x101C,0x1020): every lane from 0xAAAA1008 onward misses -> miss_cnt=7, match_cnt=3.
- LANES=2, RETRY, expected 0x1000,0x1004; group {0x1000,0x1004} -> no miss, level -=2. Group {0x2000,0x1004} against 0x1008,0x100C -> miss_pc_try=0x2000, factual=0x1008; lane1 compares to 0x1008, misses, consumes 0.
- Fill FIFO to DEPTH=8 -> ref_ready=0; simultaneous push+pop at level 8 is blocked on the push; at level 7, push+2 pops -> level 6.
- ret_valid=2'b10 -> proto_err=1, group ignores lane 1; clear -> proto_err=0, counters 0.
- Force miss_cnt to 0xFFFF, add a miss -> stays 0xFFFF. Assert rst_n=0 mid-group -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pc_lockstep_checker.sv
`default_nettype none
// ==========================================================================
// pc_lockstep_checker : in-order multi-lane retired-PC vs expected-PC compare
// Revision 1.0
// ==========================================================================
module pc_lockstep_checker #(
  parameter int XLEN  = 64,
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  clear,
  input  logic                  ref_valid,
  input  logic [XLEN-1:0]       ref_pc,
  output logic                  ref_ready,
  input  logic [LANES-1:0]      ret_valid,
  input  logic [LANES*XLEN-1:0] ret_pc,
  output logic                  ret_ready,
  output logic                  miss,
  output logic [XLEN-1:0]       miss_pc_try,
  output logic [XLEN-1:0]       miss_pc_factual,
  output logic [CNT_W-1:0]      match_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic                  sticky_err,
  output logic                  proto_err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(LANES + 1);
  localparam logic [AW-1:0] C_MASK  = AW'(DEPTH - 1);
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_LANES = LW'(LANES);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [LW-1:0]    r_level;

  logic             w_push;
  logic             w_accept;
  logic             w_proto;
  logic             w_any_miss;
  logic [LANES-1:0] w_active;
  logic [LW-1:0]    w_k;
  logic [LW-1:0]    w_pops;
  logic [NW-1:0]    w_n_match;
  logic [NW-1:0]    w_n_miss;
  logic [XLEN-1:0]  w_exp_pc;
  logic [XLEN-1:0]  w_try_pc;
  logic [XLEN-1:0]  w_try;
  logic [XLEN-1:0]  w_factual;

  // Nothing may be offered to the simulator side while reset is held.
  assign ref_ready  = rst_n && (r_level < C_DEPTH);
  assign ret_ready  = (r_level >= C_LANES);
  assign w_push     = ref_valid && ref_ready;
  assign w_accept   = ret_ready && (|ret_valid);
  assign fifo_level = r_level;

  // Active lanes form the contiguous valid prefix starting at lane 0.
  assign w_active[0] = ret_valid[0];
  generate
    if (LANES > 1) begin : g_prefix
      for (genvar i = 1; i < LANES; i++) begin : g_lane
        assign w_active[i] = ret_valid[i] & w_active[i-1];
      end
    end
  endgenerate

  assign w_proto = |(ret_valid & ~w_active);

  // w_k counts entries consumed by older lanes; a RETRY miss leaves it unchanged.
  always_comb begin
    w_k        = '0;
    w_any_miss = 1'b0;
    w_n_match  = '0;
    w_n_miss   = '0;
    w_try      = '0;
    w_factual  = '0;
    w_exp_pc   = '0;
    w_try_pc   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_active[i]) begin
        w_exp_pc = r_mem[(r_head + AW'(w_k)) & C_MASK];
        w_try_pc = ret_pc[i*XLEN +: XLEN];
        if (w_try_pc == w_exp_pc) begin
          w_n_match = w_n_match + NW'(1);
          w_k       = w_k + LW'(1);
        end else begin
          if (!w_any_miss) begin
            w_try     = w_try_pc;
            w_factual = w_exp_pc;
          end
          w_any_miss = 1'b1;
          w_n_miss   = w_n_miss + NW'(1);
          if (!mode) begin
            w_k = w_k + LW'(1);
          end
        end
      end
    end
    w_pops = w_accept ? w_k : '0;
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NW-1:0]    b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= ref_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_tail <= (r_tail + AW'(1)) & C_MASK;
      end
      r_head  <= (r_head + AW'(w_pops)) & C_MASK;
      r_level <= r_level + LW'(w_push) - w_pops;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss            <= 1'b0;
      miss_pc_try     <= '0;
      miss_pc_factual <= '0;
    end else begin
      miss <= w_accept && w_any_miss;
      if (w_accept && w_any_miss) begin
        miss_pc_try     <= w_try;
        miss_pc_factual <= w_factual;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      sticky_err <= 1'b0;
      proto_err  <= 1'b0;
    end else if (clear) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      sticky_err <= 1'b0;
      proto_err  <= 1'b0;
    end else if (w_accept) begin
      match_cnt <= sat_add(match_cnt, w_n_match);
      miss_cnt  <= sat_add(miss_cnt, w_n_miss);
      if (w_any_miss) begin
        sticky_err <= 1'b1;
      end
      if (w_proto) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
